vscale_hasti_param_sram: RTL and testbench



---
 rtl/vscale_hasti_param_sram_pkg.sv | 37 +++
 rtl/vscale_hasti_param_sram_array.sv | 27 ++
 rtl/vscale_hasti_param_sram.sv | 141 ++++++++++++++
 tb/tb_vscale_hasti_param_sram.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_hasti_param_sram_pkg.sv
// Shared HASTI bus constants, FSM state type and byte-lane helper for the
// parametrised vscale SRAM slave.
package vscale_hasti_param_sram_pkg;

  localparam int HASTI_BUS_WIDTH  = 32;
  localparam int HASTI_ADDR_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << lane;
      HSIZE_HALF: strb = 4'b0011 << lane;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/vscale_hasti_param_sram_array.sv
// DEPTH_WORDS x 32 storage with per-byte write strobes, synchronous write
// and asynchronous read; contents are never reset.
module vscale_sram_array #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int          AW          = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/vscale_hasti_param_sram.sv
// AHB-Lite (HASTI) SRAM slave with configurable depth, base address, wait
// states, byte/half/word writes and a two-cycle ERROR response.
module vscale_hasti_param_sram
  import vscale_hasti_param_sram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

  sram_state_e   state, state_next;
  logic [3:0]    counter, counter_next;
  logic          dp_valid;
  logic          dp_write;
  logic [31:0]   dp_addr;
  logic [2:0]    dp_size;

  logic          accept;
  logic [32:0]   req_offset;
  logic          req_err;
  logic          dp_done;
  logic          mem_we;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_index;
  logic [31:0]   mem_rdata;
  logic          unused_inputs;

  assign unused_inputs = ^{hburst, hmastlock, hprot, htrans[0]};

  // A borrow out of the 33-bit subtraction flags addresses below the base.
  assign accept     = hready && htrans[1];
  assign req_offset = {1'b0, haddr} - {1'b0, BASE_ADDR};

  always_comb begin
    req_err = 1'b0;
    if (req_offset[32] || ({1'b0, req_offset[31:0]} >= SPAN)) req_err = 1'b1;
    if (hsize > HSIZE_WORD) req_err = 1'b1;
    if ((hsize == HSIZE_HALF) && haddr[0]) req_err = 1'b1;
    if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) req_err = 1'b1;
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    hready       = 1'b1;
    hresp        = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_ERR2: begin
        hready = 1'b1;
        hresp  = (state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        state_next = ST_IDLE;
        if (accept) begin
          if (req_err) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_next   = ST_WAIT;
            counter_next = WS_LOAD;
          end
        end
      end
      ST_WAIT: begin
        hready = 1'b0;
        hresp  = HRESP_OKAY;
        if (counter == 4'd1) begin
          state_next   = ST_IDLE;
          counter_next = 4'd0;
        end else begin
          counter_next = counter - 4'd1;
        end
      end
      ST_ERR1: begin
        hready     = 1'b0;
        hresp      = HRESP_ERROR;
        state_next = ST_ERR2;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Address-phase registers only move when the previous data phase closes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      counter  <= 4'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
      dp_size  <= 3'd0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      if (hready) begin
        dp_valid <= accept && !req_err;
        if (accept) begin
          dp_write <= hwrite;
          dp_addr  <= haddr;
          dp_size  <= hsize;
        end
      end
    end
  end

  assign dp_done   = dp_valid && (state == ST_IDLE);
  assign mem_we    = dp_done && dp_write;
  assign mem_wstrb = byte_strobe(dp_size, dp_addr[1:0]);
  assign mem_index = AW'((dp_addr - BASE_ADDR) >> 2);
  assign hrdata    = (dp_done && !dp_write) ? mem_rdata : 32'h0;

  vscale_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (hclk),
    .we   (mem_we),
    .wstrb(mem_wstrb),
    .addr (mem_index),
    .wdata(hwdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_vscale_hasti_param_sram.sv
// Self-checking bench: a zero-wait instance at base 0 and a three-wait
// instance at base 0x400, both checked against a byte-level memory model.
module tb_vscale_hasti_param_sram;

  localparam int DEPTH = 64;

  logic        hclk;
  logic        hresetn   [2];
  logic [31:0] haddr     [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic        hmastlock [2];
  logic [3:0]  hprot     [2];
  logic [1:0]  htrans    [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hready    [2];
  logic        hresp     [2];

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [2][DEPTH];

  vscale_hasti_param_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn[0]), .haddr(haddr[0]), .hwrite(hwrite[0]),
    .hsize(hsize[0]), .hburst(hburst[0]), .hmastlock(hmastlock[0]), .hprot(hprot[0]),
    .htrans(htrans[0]), .hwdata(hwdata[0]), .hrdata(hrdata[0]), .hready(hready[0]),
    .hresp(hresp[0]));

  vscale_hasti_param_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h400), .WAIT_STATES(3)) dut1 (
    .hclk(hclk), .hresetn(hresetn[1]), .haddr(haddr[1]), .hwrite(hwrite[1]),
    .hsize(hsize[1]), .hburst(hburst[1]), .hmastlock(hmastlock[1]), .hprot(hprot[1]),
    .htrans(htrans[1]), .hwdata(hwdata[1]), .hrdata(hrdata[1]), .hready(hready[1]),
    .hresp(hresp[1]));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic [31:0] base_of(input int d);
    return (d == 1) ? 32'h400 : 32'h0;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic bit exp_err(input int d, input logic [31:0] a, input logic [2:0] s);
    longint off;
    off = longint'(a) - longint'(base_of(d));
    if (off < 0 || off >= DEPTH * 4) return 1'b1;
    if (s > 3'd2) return 1'b1;
    if (s == 3'd1 && a[0]) return 1'b1;
    if (s == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    return model_mem[d][int'((a - base_of(d)) / 4)];
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd);
    int idx;
    int lane;
    idx  = int'((a - base_of(d)) / 4);
    lane = int'(a[1:0]);
    for (int b = 0; b < 4; b++) begin
      if ((s == 3'd2) || (b == lane) || (s == 3'd1 && b == lane + 1))
        model_mem[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    end
  endtask

  // Single non-pipelined transfer; called and returns at a negedge with the slave idle.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rf,
                      output logic rl, output int lows);
    haddr[d]  = a;
    hwrite[d] = w;
    hsize[d]  = s;
    hburst[d] = 3'($urandom_range(0, 7));
    htrans[d] = 2'd2;
    @(negedge hclk);
    htrans[d] = 2'd0;
    hwdata[d] = wd;
    rf   = hresp[d];
    lows = 0;
    while (!hready[d] && lows < 40) begin
      lows++;
      @(negedge hclk);
    end
    if (lows >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL xfer_timeout: dut%0d addr %h never raised hready", d, a);
    end
    rd = hrdata[d];
    rl = hresp[d];
    @(negedge hclk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      hresetn[d] = 1'b0; haddr[d] = 32'h0; hwrite[d] = 1'b0; hsize[d] = 3'd2;
      hburst[d] = 3'd0; hmastlock[d] = 1'b0; hprot[d] = 4'h3; htrans[d] = 2'd0;
      hwdata[d] = 32'h0;
    end
    repeat (3) @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (hready[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs dut%0d: got ready=%b resp=%b rdata=%h want 1/0/0",
                 d, hready[d], hresp[d], hrdata[d]);
      end
      hresetn[d] = 1'b1;
    end
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (hready[d] !== 1'b1 || hresp[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle dut%0d: got ready=%b resp=%b want 1/0",
                 d, hready[d], hresp[d]);
      end
    end
  endtask

  task automatic test_preload();
    logic [31:0] rd, wd;
    logic rf, rl;
    int lows;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wd = $urandom;
        xfer(d, base_of(d) + 32'(i * 4), 1'b1, 3'd2, wd, rd, rf, rl, lows);
        model_write(d, base_of(d) + 32'(i * 4), 3'd2, wd);
        checks++;
        if (lows !== ws_of(d) || rl !== 1'b0) begin
          errors++;
          $display("[TB] FAIL preload_write dut%0d word %0d: got waits=%0d resp=%b want %0d/0",
                   d, i, lows, rl, ws_of(d));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] op_addr [40];
    logic        op_wr   [40];
    logic [2:0]  op_size [40];
    logic [31:0] op_data [40];
    logic [31:0] exp;
    haddr[0] = 32'h10; hwrite[0] = 1'b1; hsize[0] = 3'd2; htrans[0] = 2'd2;
    @(negedge hclk);
    checks++;
    if (hready[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_write_ready: got %b want 1", hready[0]);
    end
    hwdata[0] = 32'hDEADBEEF;
    model_write(0, 32'h10, 3'd2, 32'hDEADBEEF);
    hwrite[0] = 1'b0;
    @(negedge hclk);
    checks++;
    if (hready[0] !== 1'b1 || hrdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL b2b_read_after_write: got ready=%b rdata=%h want 1/deadbeef",
               hready[0], hrdata[0]);
    end
    htrans[0] = 2'd0;
    @(negedge hclk);
    for (int i = 0; i < 40; i++) begin
      op_size[i] = 3'($urandom_range(0, 2));
      op_addr[i] = 32'($urandom_range(0, DEPTH - 1) * 4);
      if (op_size[i] == 3'd0) op_addr[i] += 32'($urandom_range(0, 3));
      if (op_size[i] == 3'd1) op_addr[i] += 32'($urandom_range(0, 1) * 2);
      op_wr[i]   = 1'($urandom_range(0, 1));
      op_data[i] = $urandom;
    end
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        checks++;
        if (hready[0] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stream_ready op %0d: got %b want 1", i - 1, hready[0]);
        end
        if (op_wr[i-1]) begin
          hwdata[0] = op_data[i-1];
          model_write(0, op_addr[i-1], op_size[i-1], op_data[i-1]);
        end else begin
          exp = model_read(0, op_addr[i-1]);
          checks++;
          if (hrdata[0] !== exp) begin
            errors++;
            $display("[TB] FAIL stream_read op %0d addr %h: got %h want %h",
                     i - 1, op_addr[i-1], hrdata[0], exp);
          end
        end
      end
      if (i < 40) begin
        haddr[0] = op_addr[i]; hwrite[0] = op_wr[i]; hsize[0] = op_size[i]; htrans[0] = 2'd3;
      end else begin
        htrans[0] = 2'd0;
      end
      @(negedge hclk);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd;
    logic rf, rl;
    int lows;
    xfer(0, 32'h10, 1'b1, 3'd2, 32'h11223344, rd, rf, rl, lows);
    model_write(0, 32'h10, 3'd2, 32'h11223344);
    xfer(0, 32'h13, 1'b1, 3'd0, 32'hAA000000, rd, rf, rl, lows);
    model_write(0, 32'h13, 3'd0, 32'hAA000000);
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rf, rl, lows);
    checks++;
    if (rd !== 32'hAA223344 || rd !== model_read(0, 32'h10)) begin
      errors++;
      $display("[TB] FAIL byte_write: got %h want aa223344", rd);
    end
    xfer(0, 32'h10, 1'b1, 3'd2, 32'h11223344, rd, rf, rl, lows);
    model_write(0, 32'h10, 3'd2, 32'h11223344);
    xfer(0, 32'h12, 1'b1, 3'd1, 32'h5566FFFF, rd, rf, rl, lows);
    model_write(0, 32'h12, 3'd1, 32'h5566FFFF);
    xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rf, rl, lows);
    checks++;
    if (rd !== 32'h55663344 || rd !== model_read(0, 32'h10)) begin
      errors++;
      $display("[TB] FAIL half_write: got %h want 55663344", rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] a_addr, b_addr;
    a_addr = 32'h400;
    b_addr = 32'h4F8;
    haddr[1] = a_addr; hwrite[1] = 1'b0; hsize[1] = 3'd2; htrans[1] = 2'd2;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge hclk);
        if (c == 0) htrans[1] = 2'd0;
        checks++;
        if (hready[1] !== 1'b0 || hresp[1] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL wait_low read %0d cycle %0d: got ready=%b resp=%b want 0/0",
                   k, c, hready[1], hresp[1]);
        end
      end
      @(negedge hclk);
      checks++;
      if (hready[1] !== 1'b1 || hrdata[1] !== model_read(1, (k == 0) ? a_addr : b_addr)) begin
        errors++;
        $display("[TB] FAIL wait_complete read %0d: got ready=%b rdata=%h want 1/%h", k,
                 hready[1], hrdata[1], model_read(1, (k == 0) ? a_addr : b_addr));
      end
      if (k == 0) begin
        haddr[1] = b_addr; htrans[1] = 2'd2;
      end
    end
    @(negedge hclk);
  endtask

  task automatic test_errors();
    int          e_dut  [6] = '{0, 0, 0, 0, 1, 1};
    logic [31:0] e_addr [6] = '{32'h100, 32'h2, 32'h4, 32'h1, 32'h3FC, 32'h500};
    logic [2:0]  e_size [6] = '{3'd2, 3'd2, 3'd3, 3'd1, 3'd2, 3'd2};
    logic [31:0] e_back [6] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h4FC, 32'h400};
    logic [31:0] rd;
    logic rf, rl;
    int lows;
    for (int i = 0; i < 6; i++) begin
      xfer(e_dut[i], e_addr[i], 1'b1, e_size[i], $urandom, rd, rf, rl, lows);
      checks++;
      if (rf !== 1'b1 || lows !== 1 || rl !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("[TB] FAIL error_resp case %0d: got resp1=%b waits=%0d resp2=%b rdata=%h want 1/1/1/0",
                 i, rf, lows, rl, rd);
      end
      xfer(e_dut[i], e_back[i], 1'b0, 3'd2, 32'h0, rd, rf, rl, lows);
      checks++;
      if (rd !== model_read(e_dut[i], e_back[i]) || rl !== 1'b0) begin
        errors++;
        $display("[TB] FAIL error_no_write case %0d: got %h resp=%b want %h/0",
                 i, rd, rl, model_read(e_dut[i], e_back[i]));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic rf, rl;
    int lows;
    haddr[1] = 32'h420; hwrite[1] = 1'b1; hsize[1] = 3'd2; htrans[1] = 2'd2;
    @(negedge hclk);
    htrans[1] = 2'd0;
    hwdata[1] = ~model_read(1, 32'h420);
    checks++;
    if (hready[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_waiting: got ready=%b want 0", hready[1]);
    end
    #2 hresetn[1] = 1'b0;
    #1;
    checks++;
    if (hready[1] !== 1'b1 || hresp[1] !== 1'b0 || hrdata[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got ready=%b resp=%b rdata=%h want 1/0/0",
               hready[1], hresp[1], hrdata[1]);
    end
    repeat (3) @(negedge hclk);
    hresetn[1] = 1'b1;
    @(negedge hclk);
    xfer(1, 32'h420, 1'b0, 3'd2, 32'h0, rd, rf, rl, lows);
    checks++;
    if (rd !== model_read(1, 32'h420)) begin
      errors++;
      $display("[TB] FAIL reset_mid_unchanged: got %h want %h", rd, model_read(1, 32'h420));
    end
  endtask

  task automatic test_busy_idle();
    int lows;
    for (int k = 0; k < 2; k++) begin
      haddr[1] = (k == 0) ? 32'h408 : 32'h40C; hwrite[1] = 1'b0; hsize[1] = 3'd2;
      htrans[1] = 2'd2;
      @(negedge hclk);
      htrans[1] = 2'd0;
      lows = 0;
      while (!hready[1] && lows < 40) begin
        lows++;
        @(negedge hclk);
      end
      checks++;
      if (lows !== 3 || hrdata[1] !== model_read(1, (k == 0) ? 32'h408 : 32'h40C)) begin
        errors++;
        $display("[TB] FAIL busy_idle_read %0d: got waits=%0d rdata=%h want 3/%h", k, lows,
                 hrdata[1], model_read(1, (k == 0) ? 32'h408 : 32'h40C));
      end
      if (k == 0) begin
        htrans[1] = 2'd1;
        @(negedge hclk);
        checks++;
        if (hready[1] !== 1'b1 || hresp[1] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_resp: got ready=%b resp=%b want 1/0", hready[1], hresp[1]);
        end
        htrans[1] = 2'd0;
        @(negedge hclk);
        checks++;
        if (hready[1] !== 1'b1 || hresp[1] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL idle_resp: got ready=%b resp=%b want 1/0", hready[1], hresp[1]);
        end
      end
    end
    @(negedge hclk);
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd;
    logic [2:0]  s;
    logic        w, rf, rl, err;
    int lows;
    for (int i = 0; i < 30; i++) begin
      a   = 32'h400 - 32'd8 + 32'($urandom_range(0, DEPTH * 4 + 15));
      s   = 3'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      wd  = $urandom;
      err = exp_err(1, a, s);
      xfer(1, a, w, s, wd, rd, rf, rl, lows);
      checks++;
      if (err) begin
        if (rf !== 1'b1 || lows !== 1 || rl !== 1'b1) begin
          errors++;
          $display("[TB] FAIL random_err %0d addr %h size %0d: got %b/%0d/%b want 1/1/1",
                   i, a, s, rf, lows, rl);
        end
      end else begin
        if (lows !== 3 || rl !== 1'b0 || (!w && rd !== model_read(1, a))) begin
          errors++;
          $display("[TB] FAIL random_ok %0d addr %h size %0d: got waits=%0d resp=%b rdata=%h want 3/0/%h",
                   i, a, s, lows, rl, rd, w ? rd : model_read(1, a));
        end
        if (w) model_write(1, a, s, wd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_back_to_back();
    test_byte_half();
    test_wait_states();
    test_errors();
    test_reset_mid();
    test_busy_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
